// File: rtl/yqc_key_filter.sv
// rtl/yqc_key_filter.sv - push-button synchroniser, debouncer and press-pulse generator
// Each key runs its own qualify/hold FSM; press and auto-repeat events become one-cycle pulses.
module yqc_key_filter #(
    parameter int NUM_KEYS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_RATE     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                key_valid,
    output logic [1:0]          key_code,
    output logic                multi_key
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_QUAL = 2'd1,
        HELD       = 2'd2,
        REL_QUAL   = 2'd3
    } state_t;

    localparam logic [NUM_KEYS-1:0] RAW_IDLE = ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};
    localparam logic [CNT_W-1:0]    DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0]    RATE_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] pulse_d;
    logic [1:0]          code_d;

    // Sync flops hold the raw (un-normalised) value so reset can load "not pressed".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] cnt_inc;
        logic             rep_q;
        logic             rep_d;
        logic             level_q;
        logic             level_d;
        logic             fire;
        logic             p;

        assign p       = pressed[k];
        assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_ONE;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rep_q   <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rep_q   <= rep_d;
                level_q <= level_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE: begin
                    if (p) state_d = PRESS_QUAL;
                end
                PRESS_QUAL: begin
                    if (!p)                    state_d = IDLE;
                    else if (cnt_q >= DEB_LAST) state_d = HELD;
                end
                HELD: begin
                    if (!p) state_d = REL_QUAL;
                end
                REL_QUAL: begin
                    if (p)                     state_d = HELD;
                    else if (cnt_q >= DEB_LAST) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // cnt doubles as the repeat timer while HELD; rep_q marks the post-delay phase.
        always_comb begin
            cnt_d   = cnt_q;
            rep_d   = rep_q;
            level_d = level_q;
            fire    = 1'b0;
            case (state_q)
                IDLE: begin
                    rep_d = 1'b0;
                    cnt_d = p ? CNT_ONE : '0;
                end
                PRESS_QUAL: begin
                    if (!p) begin
                        cnt_d = '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        cnt_d   = '0;
                        rep_d   = 1'b0;
                        level_d = 1'b1;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!p) begin
                        cnt_d = CNT_ONE;
                        rep_d = 1'b0;
                    end else if (REPEAT_DELAY > 0) begin
                        if ((!rep_q && cnt_q >= DLY_LAST) || (rep_q && cnt_q >= RATE_LAST)) begin
                            fire  = 1'b1;
                            rep_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                REL_QUAL: begin
                    if (p) begin
                        cnt_d = '0;
                        rep_d = 1'b0;
                    end else if (cnt_q >= DEB_LAST) begin
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign pulse_d[k]   = fire;
        assign level_vec[k] = level_q;
    end

    always_comb begin
        code_d = 2'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pulse_d[i]) code_d = 2'(i);
        end
    end

    // Pulse, valid and code share one register stage so they can never skew.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pulse <= '0;
            key_valid <= 1'b0;
            key_code  <= 2'd0;
        end else begin
            key_pulse <= pulse_d;
            key_valid <= |pulse_d;
            key_code  <= code_d;
        end
    end

    assign key_level = level_vec;
    assign multi_key = |(level_vec & (level_vec - NUM_KEYS'(1)));

endmodule

// File: tb/tb_yqc_key_filter.sv
// tb/tb_yqc_key_filter.sv - scoreboard bench for yqc_key_filter (repeat and no-repeat instances)
module tb_yqc_key_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_a;
    logic [3:0] btn_b;
    logic [3:0] lvl_a, pls_a, lvl_b, pls_b;
    logic       val_a, multi_a, val_b, multi_b;
    logic [1:0] code_a, code_b;

    yqc_key_filter #(
        .NUM_KEYS(4), .ACTIVE_LOW(1'b1), .CNT_W(20),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_raw(btn_a),
        .key_level(lvl_a), .key_pulse(pls_a), .key_valid(val_a),
        .key_code(code_a), .multi_key(multi_a)
    );

    yqc_key_filter #(
        .NUM_KEYS(4), .ACTIVE_LOW(1'b1), .CNT_W(20),
        .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(3)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_raw(btn_b),
        .key_level(lvl_b), .key_pulse(pls_b), .key_valid(val_b),
        .key_code(code_b), .multi_key(multi_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] pulse;
        logic [1:0] code;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    function automatic exp_t mk(input int c, input logic [3:0] p, input logic [1:0] k);
        exp_t e;
        e.cyc = c; e.pulse = p; e.code = k;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (val_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_pulse", int'(pls_a), 0);
                end else begin
                    ea = q_a.pop_front();
                    chk("a_pulse_cycle", cyc, ea.cyc);
                    chk("a_pulse_vec", int'(pls_a), int'(ea.pulse));
                    chk("a_code", int'(code_a), int'(ea.code));
                end
            end else begin
                chk("a_idle_pulse_code", int'({pls_a, code_a}), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (val_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_pulse", int'(pls_b), 0);
                end else begin
                    eb = q_b.pop_front();
                    chk("b_pulse_cycle", cyc, eb.cyc);
                    chk("b_pulse_vec", int'(pls_b), int'(eb.pulse));
                    chk("b_code", int'(code_b), int'(eb.code));
                end
            end else begin
                chk("b_idle_pulse_code", int'({pls_b, code_b}), 0);
            end
        end
    end

    initial begin
        int t0;
        int t1;
        btn_a = 4'hF;
        btn_b = 4'hF;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", int'({lvl_a, pls_a, val_a, code_a, multi_a}), 0);
        chk("reset_outputs_b", int'({lvl_b, pls_b, val_b, code_b, multi_b}), 0);
        rst = 1'b0;
        wait_until(cyc + 5);

        // single press, no auto-repeat
        t0 = cyc;
        btn_b[2] = 1'b0;
        q_b.push_back(mk(t0 + 6, 4'b0100, 2'd2));
        wait_until(t0 + 10);
        chk("t1_level_held", int'(lvl_b), 4'b0100);
        wait_until(t0 + 30);
        btn_b[2] = 1'b1;
        wait_until(t0 + 35);
        chk("t1_level_before_release", int'(lvl_b), 4'b0100);
        wait_until(t0 + 36);
        chk("t1_level_released", int'(lvl_b), 0);
        wait_until(t0 + 40);

        // 3-cycle glitch is one sample short of qualifying
        t0 = cyc;
        btn_a[0] = 1'b0;
        wait_until(t0 + 3);
        btn_a[0] = 1'b1;
        wait_until(t0 + 10);
        chk("t2_glitch_level", int'(lvl_a), 0);

        // auto-repeat: press, delay 10, rate 3
        t0 = cyc;
        btn_a[1] = 1'b0;
        q_a.push_back(mk(t0 + 6,  4'b0010, 2'd1));
        q_a.push_back(mk(t0 + 16, 4'b0010, 2'd1));
        q_a.push_back(mk(t0 + 19, 4'b0010, 2'd1));
        q_a.push_back(mk(t0 + 22, 4'b0010, 2'd1));
        q_a.push_back(mk(t0 + 25, 4'b0010, 2'd1));
        wait_until(t0 + 25);
        btn_a[1] = 1'b1;
        wait_until(t0 + 30);
        chk("t3_level_before_release", int'(lvl_a), 4'b0010);
        wait_until(t0 + 31);
        chk("t3_level_released", int'(lvl_a), 0);
        wait_until(t0 + 35);

        // simultaneous press of keys 0 and 3
        t0 = cyc;
        btn_a = 4'b0110;
        q_a.push_back(mk(t0 + 6, 4'b1001, 2'd0));
        wait_until(t0 + 8);
        chk("t4_level_both", int'(lvl_a), 4'b1001);
        chk("t4_multi_key", int'(multi_a), 1);
        btn_a = 4'hF;
        wait_until(t0 + 14);
        chk("t4_level_released", int'(lvl_a), 0);
        chk("t4_multi_clear", int'(multi_a), 0);
        wait_until(t0 + 20);

        // release bounce while held
        t0 = cyc;
        btn_b[1] = 1'b0;
        q_b.push_back(mk(t0 + 6, 4'b0010, 2'd1));
        wait_until(t0 + 10); btn_b[1] = 1'b1;
        wait_until(t0 + 11); btn_b[1] = 1'b0;
        wait_until(t0 + 12); btn_b[1] = 1'b1;
        wait_until(t0 + 13); btn_b[1] = 1'b0;
        wait_until(t0 + 15);
        chk("t5_level_during_bounce", int'(lvl_b), 4'b0010);
        wait_until(t0 + 20);
        chk("t5_level_after_bounce", int'(lvl_b), 4'b0010);
        btn_b[1] = 1'b1;
        wait_until(t0 + 26);
        chk("t5_level_released", int'(lvl_b), 0);
        wait_until(t0 + 30);

        // reset mid-qualify (dut_a) and mid-hold (dut_b)
        t0 = cyc;
        btn_b[0] = 1'b0;
        q_b.push_back(mk(t0 + 6, 4'b0001, 2'd0));
        wait_until(t0 + 10);
        t0 = cyc;
        btn_a[3] = 1'b0;
        wait_until(t0 + 4);
        chk("t6_level_b_before_reset", int'(lvl_b), 4'b0001);
        rst = 1'b1;
        #1;
        chk("t6_reset_outputs_a", int'({lvl_a, pls_a, val_a, code_a, multi_a}), 0);
        chk("t6_reset_outputs_b", int'({lvl_b, pls_b, val_b, code_b, multi_b}), 0);
        wait_until(t0 + 6);
        rst = 1'b0;
        t1 = cyc;
        q_a.push_back(mk(t1 + 6, 4'b1000, 2'd3));
        q_b.push_back(mk(t1 + 6, 4'b0001, 2'd0));
        wait_until(t1 + 5);
        chk("t6_level_a_not_yet", int'(lvl_a), 0);
        wait_until(t1 + 10);
        chk("t6_level_a_requal", int'(lvl_a), 4'b1000);
        chk("t6_level_b_requal", int'(lvl_b), 4'b0001);
        btn_a = 4'hF;
        btn_b = 4'hF;
        wait_until(t1 + 20);

        chk("a_expected_pulses_left", q_a.size(), 0);
        chk("b_expected_pulses_left", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
